// File: rtl/code_lock_ctrl.sv
// Combination-lock sequencer: collects keypad digits, checks them against the stored code,
// and drives the display digits, tries count and the unlocked/alarm/setting flags.
module code_lock_ctrl #(
  parameter logic [11:0] DEFAULT_CODE = 12'h123,
  parameter int unsigned MAX_TRIES    = 3,
  parameter int unsigned UNLOCK_CYC   = 500_000_000,
  parameter int unsigned LOCKOUT_CYC  = 250_000_000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] data,
  output logic [1:0]  tries,
  output logic        unlocked,
  output logic        alarm,
  output logic        setting
);

  typedef enum logic [2:0] {
    S_ENTRY    = 3'd0,
    S_CHECK    = 3'd1,
    S_UNLOCKED = 3'd2,
    S_SET      = 3'd3,
    S_LOCKOUT  = 3'd4
  } state_t;

  localparam logic [3:0]  KEY_ENTER    = 4'hA;
  localparam logic [3:0]  KEY_CLEAR    = 4'hB;
  localparam logic [3:0]  KEY_SET      = 4'hC;
  localparam logic [3:0]  KEY_LOCK     = 4'hD;
  localparam logic [31:0] UNLOCK_LOAD  = 32'(UNLOCK_CYC - 1);
  localparam logic [31:0] LOCKOUT_LOAD = 32'(LOCKOUT_CYC - 1);
  localparam logic [1:0]  TRIES_LIMIT  = 2'(MAX_TRIES);

  state_t      state, state_n;
  logic [11:0] entry_buf, buf_n;
  logic [1:0]  cnt, cnt_n;
  logic [11:0] code, code_n;
  logic [31:0] timer, timer_n;
  logic [1:0]  tries_n;
  logic [11:0] data_n;

  logic is_digit, is_enter, is_clear, is_set, is_lock, buf_full, last_try;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign is_clear = key_valid && (key_code == KEY_CLEAR);
  assign is_set   = key_valid && (key_code == KEY_SET);
  assign is_lock  = key_valid && (key_code == KEY_LOCK);
  assign buf_full = (cnt == 2'd3);
  assign last_try = (({1'b0, tries} + 3'd1) == {1'b0, TRIES_LIMIT});

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    buf_n   = entry_buf;
    cnt_n   = cnt;
    code_n  = code;
    timer_n = timer;
    tries_n = tries;

    case (state)
      S_ENTRY, S_SET: begin
        timer_n = '0;
        if (is_digit) begin
          if (!buf_full) begin
            buf_n = {entry_buf[7:0], key_code};
            cnt_n = cnt + 2'd1;
          end
        end else if (is_clear) begin
          buf_n = '0;
          cnt_n = '0;
        end else if (is_enter && buf_full) begin
          if (state == S_ENTRY) begin
            state_n = S_CHECK;
          end else begin
            code_n  = entry_buf;
            buf_n   = '0;
            cnt_n   = '0;
            state_n = S_ENTRY;
          end
        end else if (is_lock && state == S_SET) begin
          buf_n   = '0;
          cnt_n   = '0;
          state_n = S_ENTRY;
        end
      end

      // Single evaluation cycle; keys arriving now are deliberately dropped.
      S_CHECK: begin
        buf_n = '0;
        cnt_n = '0;
        if (entry_buf == code) begin
          state_n = S_UNLOCKED;
          tries_n = '0;
          timer_n = UNLOCK_LOAD;
        end else if (last_try) begin
          state_n = S_LOCKOUT;
          tries_n = TRIES_LIMIT;
          timer_n = LOCKOUT_LOAD;
        end else begin
          state_n = S_ENTRY;
          tries_n = tries + 2'd1;
          timer_n = '0;
        end
      end

      // Expiry wins over keys; D at expiry lands in ENTRY either way.
      S_UNLOCKED: begin
        if (timer == '0) begin
          state_n = S_ENTRY;
        end else if (is_lock) begin
          state_n = S_ENTRY;
          timer_n = '0;
        end else if (is_set) begin
          state_n = S_SET;
          buf_n   = '0;
          cnt_n   = '0;
          timer_n = '0;
        end else begin
          timer_n = timer - 32'd1;
        end
      end

      S_LOCKOUT: begin
        if (timer == '0) begin
          state_n = S_ENTRY;
          tries_n = '0;
        end else begin
          timer_n = timer - 32'd1;
        end
      end

      default: begin
        state_n = S_ENTRY;
        buf_n   = '0;
        cnt_n   = '0;
        timer_n = '0;
      end
    endcase

    case (state_n)
      S_UNLOCKED: data_n = code_n;
      S_LOCKOUT:  data_n = '0;
      default:    data_n = buf_n;
    endcase
  end

  // Outputs are registered from the next-state values so a key shows up one cycle later.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= S_ENTRY;
      entry_buf <= '0;
      cnt       <= '0;
      code      <= DEFAULT_CODE;
      timer     <= '0;
      data      <= '0;
      tries     <= '0;
      unlocked  <= 1'b0;
      alarm     <= 1'b0;
      setting   <= 1'b0;
    end else begin
      state     <= state_n;
      entry_buf <= buf_n;
      cnt       <= cnt_n;
      code      <= code_n;
      timer     <= timer_n;
      data      <= data_n;
      tries     <= tries_n;
      unlocked  <= (state_n == S_UNLOCKED);
      alarm     <= (state_n == S_LOCKOUT);
      setting   <= (state_n == S_SET);
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: a behavioural lock model predicts each cycle's
// outputs into a queue and an independent monitor compares them against the DUT.
module tb_code_lock_ctrl;

  localparam int UNLOCK_CYC  = 10;
  localparam int LOCKOUT_CYC = 20;
  localparam int MAX_TRIES   = 3;

  logic        clk = 1'b0;
  logic        RST;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] data;
  logic [1:0]  tries;
  logic        unlocked, alarm, setting;

  always #5 clk = ~clk;

  code_lock_ctrl #(
    .DEFAULT_CODE(12'h123),
    .MAX_TRIES   (MAX_TRIES),
    .UNLOCK_CYC  (UNLOCK_CYC),
    .LOCKOUT_CYC (LOCKOUT_CYC)
  ) dut (
    .clk      (clk),
    .RST      (RST),
    .key_valid(key_valid),
    .key_code (key_code),
    .data     (data),
    .tries    (tries),
    .unlocked (unlocked),
    .alarm    (alarm),
    .setting  (setting)
  );

  typedef struct packed {
    logic [11:0] data;
    logic [1:0]  tries;
    logic        unlocked;
    logic        alarm;
    logic        setting;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: digits typed so far, stored code as three digits, fail count, time left.
  typedef enum {M_ENTRY, M_CHECK, M_OPEN, M_SET, M_LOCKED} mode_t;
  mode_t m_mode;
  int    m_digits[$];
  int    m_code[3];
  int    m_fails;
  int    m_remain;

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  function automatic int code_value();
    return m_code[0] * 256 + m_code[1] * 16 + m_code[2];
  endfunction

  task automatic model_reset();
    m_mode   = M_ENTRY;
    m_digits.delete();
    m_code   = '{1, 2, 3};
    m_fails  = 0;
    m_remain = 0;
  endtask

  task automatic model_step(input bit kv, input int k);
    case (m_mode)
      M_ENTRY, M_SET: begin
        if (kv) begin
          if (k <= 9) begin
            if (m_digits.size() < 3) m_digits.push_back(k);
          end else if (k == 11) begin
            m_digits.delete();
          end else if (k == 10 && m_digits.size() == 3) begin
            if (m_mode == M_ENTRY) m_mode = M_CHECK;
            else begin
              for (int i = 0; i < 3; i++) m_code[i] = m_digits[i];
              m_digits.delete();
              m_mode = M_ENTRY;
            end
          end else if (k == 13 && m_mode == M_SET) begin
            m_digits.delete();
            m_mode = M_ENTRY;
          end
        end
      end
      M_CHECK: begin
        if (digits_value() == code_value()) begin
          m_mode = M_OPEN; m_fails = 0; m_remain = UNLOCK_CYC;
        end else if (m_fails + 1 == MAX_TRIES) begin
          m_mode = M_LOCKED; m_fails = MAX_TRIES; m_remain = LOCKOUT_CYC;
        end else begin
          m_mode = M_ENTRY; m_fails++;
        end
        m_digits.delete();
      end
      M_OPEN: begin
        m_remain--;
        if (m_remain == 0 || (kv && k == 13)) m_mode = M_ENTRY;
        else if (kv && k == 12) begin
          m_mode = M_SET;
          m_digits.delete();
        end
      end
      M_LOCKED: begin
        m_remain--;
        if (m_remain == 0) begin
          m_mode = M_ENTRY; m_fails = 0;
        end
      end
      default: m_mode = M_ENTRY;
    endcase
  endtask

  function automatic out_t model_out();
    out_t o;
    case (m_mode)
      M_OPEN:   o.data = 12'(code_value());
      M_LOCKED: o.data = 12'h000;
      default:  o.data = 12'(digits_value());
    endcase
    o.tries    = 2'(m_fails);
    o.unlocked = (m_mode == M_OPEN);
    o.alarm    = (m_mode == M_LOCKED);
    o.setting  = (m_mode == M_SET);
    return o;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s @%0t: got data=%03h tries=%0d unlocked=%0b alarm=%0b setting=%0b, want data=%03h tries=%0d unlocked=%0b alarm=%0b setting=%0b",
               name, $time, act.data, act.tries, act.unlocked, act.alarm, act.setting,
               want.data, want.tries, want.unlocked, want.alarm, want.setting);
    end
  endtask

  function automatic out_t dut_out();
    return {data, tries, unlocked, alarm, setting};
  endfunction

  // Monitor: outputs settle just after each active edge; compare against the oldest prediction.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_out("cycle", dut_out(), exp_q.pop_front());
    end
  end

  task automatic step(input bit kv, input int k);
    @(negedge clk);
    key_valid = kv;
    key_code  = 4'(k);
    model_step(kv, k);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic press(input int k);
    step(1'b1, k);
    step(1'b0, 0);
  endtask

  task automatic enter3(input int a, input int b, input int c);
    press(a); press(b); press(c); press(10);
    idle(2);
  endtask

  task automatic async_reset();
    @(negedge clk);
    key_valid = 1'b0;
    #2 RST = 1'b1;
    #1 check_out("async_reset", dut_out(), '0);
    model_reset();
    @(negedge clk);
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    model_reset();
    #12 check_out("reset", dut_out(), '0);
    @(negedge clk);
    RST = 1'b0;

    // Correct code, then let the open window expire.
    enter3(1, 2, 3);
    idle(12);

    // Overflow digit ignored, clear, and enter with too few digits.
    press(4); press(5); press(6); press(7);
    press(11); press(10);
    idle(2);

    // Re-key to 705, old code now fails, new code opens; D relocks.
    enter3(1, 2, 3);
    press(12);
    press(7); press(0); press(5); press(10);
    enter3(1, 2, 3);
    enter3(7, 0, 5);
    press(13);
    idle(2);

    // Key in the check cycle is dropped; E/F ignored while open and in entry.
    press(7); press(0); press(5);
    step(1'b1, 10);
    step(1'b1, 4);
    press(14); press(15);
    press(13);
    press(1); press(15); press(14);
    press(11);

    // Three failures into lockout; keys during lockout are ignored.
    enter3(9, 9, 9);
    enter3(9, 9, 9);
    enter3(9, 9, 9);
    press(7); press(0); press(5); press(10); press(11);
    idle(LOCKOUT_CYC);

    // Second lockout, interrupted by an asynchronous reset; the code reverts to 123.
    enter3(9, 9, 9);
    enter3(9, 9, 9);
    enter3(9, 9, 9);
    idle(4);
    async_reset();
    enter3(1, 2, 3);
    idle(12);

    // Randomised key traffic, biased towards the code digits so unlocks and re-keys occur.
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 2) == 0) begin
        r = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 15));
        step(1'b1, r);
      end else begin
        step(1'b0, 0);
      end
    end

    @(negedge clk);
    key_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
